// File: rtl/bus_burst_framer.sv
// bus_burst_framer: FIFO-buffered stream framer. Upstream words are queued
// in order and re-emitted downstream in bursts of BURST_LEN words, with
// last_src marking the final word of each burst and frame_cnt counting the
// completed bursts (wrapping at 16 bits).
// Optional feature macro: BUS_FRAMER_PARITY_EN adds the parity_src output
// (XOR of all bits of the head word).
module bus_burst_framer #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_dnt,
    input  logic [WIDTH-1:0] data_dnt,
    output logic             ready_dnt,
    output logic             valid_src,
    output logic [WIDTH-1:0] data_src,
    output logic             last_src,
    input  logic             ready_src,
    output logic [15:0]      frame_cnt
`ifdef BUS_FRAMER_PARITY_EN
    ,
    output logic             parity_src
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [OW-1:0] FULL_OCC  = OW'(DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    // Word storage; read is asynchronous so the head word is always visible.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    state_t        state_q, state_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic accept;
    logic emit;

    // Handshake flags depend only on registered occupancy, so ready_src never
    // reaches ready_dnt combinationally.
    assign ready_dnt = (occ_q != FULL_OCC);
    assign valid_src = (occ_q != '0);
    assign data_src  = mem[rd_ptr_q];
    assign last_src  = valid_src && (beat_cnt_q == LAST_BEAT);
    assign frame_cnt = frame_cnt_q;

    assign accept = valid_dnt && ready_dnt;
    assign emit   = valid_src && ready_src;

`ifdef BUS_FRAMER_PARITY_EN
    // Parity of the head word; meaningful only while valid_src is high.
    assign parity_src = valid_src && (^data_src);
`endif

    // Next-state computation for pointers, occupancy, burst tracking and
    // the completed-burst counter.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        beat_cnt_d  = beat_cnt_q;
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (emit) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({accept, emit})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase

        if (emit) begin
            if (beat_cnt_q == LAST_BEAT) begin
                beat_cnt_d  = '0;
                state_d     = IDLE;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                beat_cnt_d = beat_cnt_q + BW'(1);
                state_d    = BURST;
            end
        end
    end

    // Control state registers; reset discards queued words and any partial burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            beat_cnt_q  <= '0;
            state_q     <= IDLE;
            frame_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            beat_cnt_q  <= beat_cnt_d;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Storage write at the tail; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[wr_ptr_q] <= data_dnt;
        end
    end

endmodule

// File: tb/tb_bus_burst_framer.sv
// Testbench for bus_burst_framer: queue-based reference model driven by
// directed and random stimulus, plus a BURST_LEN=1 instance that exercises
// the 16-bit frame counter wrap.
module tb_bus_burst_framer;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int BL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic          rst, valid_dnt, ready_dnt, valid_src, last_src, ready_src;
    logic [W-1:0]  data_dnt, data_src;
    logic [15:0]   frame_cnt;

    // Wrap instance signals
    logic          rst2, valid2_dnt, ready2_dnt, valid2_src, last2_src, ready2_src;
    logic [7:0]    data2_dnt, data2_src;
    logic [15:0]   frame2_cnt;

`ifdef BUS_FRAMER_PARITY_EN
    logic parity_src, parity2_src;
`endif

    bus_burst_framer #(.WIDTH(W), .DEPTH(D), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .valid_dnt(valid_dnt), .data_dnt(data_dnt), .ready_dnt(ready_dnt),
        .valid_src(valid_src), .data_src(data_src), .last_src(last_src),
        .ready_src(ready_src), .frame_cnt(frame_cnt)
`ifdef BUS_FRAMER_PARITY_EN
        , .parity_src(parity_src)
`endif
    );

    bus_burst_framer #(.WIDTH(8), .DEPTH(2), .BURST_LEN(1)) dut2 (
        .clk(clk), .rst(rst2),
        .valid_dnt(valid2_dnt), .data_dnt(data2_dnt), .ready_dnt(ready2_dnt),
        .valid_src(valid2_src), .data_src(data2_src), .last_src(last2_src),
        .ready_src(ready2_src), .frame_cnt(frame2_cnt)
`ifdef BUS_FRAMER_PARITY_EN
        , .parity_src(parity2_src)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a queue of buffered words, the beat position within
    // the current burst and the number of completed bursts.
    logic [W-1:0] mq[$];
    int           beats  = 0;
    int           frames = 0;
    bit           last_acc;

    // One clock cycle: apply inputs, compare outputs against the model,
    // then advance the model across the rising edge.
    task automatic cycle(input bit r, input bit v, input logic [W-1:0] d, input bit rs);
        bit m_valid, m_ready, acc, emt;
        rst = r; valid_dnt = v; data_dnt = d; ready_src = rs;
        #1;
        m_valid = (mq.size() != 0);
        m_ready = (mq.size() != D);
        check("valid_src", valid_src, m_valid);
        check("ready_dnt", ready_dnt, m_ready);
        check("frame_cnt", frame_cnt, frames);
        if (m_valid) begin
            check("data_src", data_src, mq[0]);
            check("last_src", last_src, beats == BL - 1);
`ifdef BUS_FRAMER_PARITY_EN
            check("parity_src", parity_src, ^mq[0]);
`endif
        end else begin
            check("last_idle", last_src, 0);
        end
        acc = !r && v && m_ready;
        emt = !r && m_valid && rs;
        @(posedge clk);
        if (r) begin
            mq.delete();
            beats  = 0;
            frames = 0;
        end else begin
            if (emt) begin
                void'(mq.pop_front());
                beats = (beats + 1) % BL;
                if (beats == 0) frames = (frames + 1) % 65536;
            end
            if (acc) mq.push_back(d);
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    // Offer a word until the model says it was accepted (bounded).
    task automatic send(input logic [W-1:0] d, input bit rs);
        for (int k = 0; k < 20; k++) begin
            cycle(0, 1, d, rs);
            if (last_acc) return;
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, '0, 1);
    endtask

    initial begin
        int n2;
        bit e2;
        rst = 1'b1; valid_dnt = 1'b0; data_dnt = '0; ready_src = 1'b0;
        rst2 = 1'b1; valid2_dnt = 1'b0; data2_dnt = '0; ready2_src = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", valid_src, 0);
        check("rst_last", last_src, 0);
        check("rst_ready", ready_dnt, 1);
        check("rst_frame", frame_cnt, 0);

        // Streaming
        cycle(0, 1, 32'h1, 1);
        cycle(0, 1, 32'h2, 1);
        cycle(0, 1, 32'h3, 1);
        cycle(0, 1, 32'h4, 1);
        drain(3);
        check("stream_frame", frame_cnt, 1);

        // Backpressure: fill, then offer while full
        send(32'h5, 0); send(32'h6, 0); send(32'h7, 0); send(32'h8, 0);
        check("bp_full_ready", ready_dnt, 0);
        cycle(0, 1, 32'h9, 1'b0);
        check("bp_held_ready", ready_dnt, 0);
        check("bp_held_data", data_src, 32'h5);
        send(32'h9, 1);
        drain(6);
        check("bp_frame", frame_cnt, 2);

        // Reset mid-burst with two words stored
        send(32'hA, 1); send(32'hB, 1);
        drain(1);
        send(32'hC, 0); send(32'hD, 0);
        cycle(1, 0, '0, 0);
        check("mid_rst_valid", valid_src, 0);
        check("mid_rst_ready", ready_dnt, 1);
        check("mid_rst_frame", frame_cnt, 0);
        for (int i = 0; i < 4; i++) send(32'h100 + i, 1);
        drain(2);
        check("mid_rst_new_frame", frame_cnt, 1);

        // Concurrent accept/emit at occupancy 2, across several pointer wraps
        send(32'h10, 0); send(32'h11, 0);
        for (int i = 0; i < 3 * D + 2; i++) begin
            cycle(0, 1, 32'h20 + i, 1);
            check("conc_occ", dut.occ_q, 2);
        end
        drain(4);

`ifdef BUS_FRAMER_PARITY_EN
        send(32'h7, 0);
        check("parity_7", parity_src, 1);
        drain(1);
        send(32'h3, 0);
        check("parity_3", parity_src, 0);
        drain(1);
`endif

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                  $urandom, $urandom_range(0, 3) != 0);
        end
        drain(6);

        // Frame counter wrap on the BURST_LEN=1 instance: every word is last
        @(negedge clk);
        rst2 = 1'b0; valid2_dnt = 1'b1;
        n2 = 0;
        for (int c = 0; c < 70000 && n2 < 65536; c++) begin
            e2 = valid2_src && ready2_src;
            if (n2 == 1000 && e2) begin
                check("wrap_last", last2_src, 1);
                check("wrap_mid", frame2_cnt, n2);
            end
            if (n2 == 65535 && e2) check("wrap_pre", frame2_cnt, 16'hFFFF);
            @(posedge clk);
            if (e2) n2++;
            data2_dnt = data2_dnt + 8'd1;
            @(negedge clk);
        end
        check("wrap_count", n2, 65536);
        check("wrap_post", frame2_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
